// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NRD_DEF    = 2;

  // Register 0 is read-only zero when zero_r0 is set.
  function automatic logic addr_writable(input int unsigned addr, input logic zero_r0);
    return !(zero_r0 && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read ports, write port, reservation and status.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NRD    = NRD_DEF
) ();

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_ready;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  rsv_en;
  logic [ADDR_W-1:0]     rsv_addr;
  logic                  flush;
  logic [ADDR_W:0]       busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_ready, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_ready, busy_cnt
  );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Pending-bit scoreboard: tracks reserved destinations and their population count.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  input  logic                  flush,
  output logic [2**ADDR_W-1:0]  pending,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] pend_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Write clears, reservation then sets (so it wins on the same address), flush overrides both.
  always_comb begin
    pend_nxt = pending;
    cnt_nxt  = '0;
    if (wr_en && addr_writable(32'(wr_addr), ZERO_R0 != 0))
      pend_nxt[wr_addr] = 1'b0;
    if (rsv_en && addr_writable(32'(rsv_addr), ZERO_R0 != 0))
      pend_nxt[rsv_addr] = 1'b1;
    if (flush)
      pend_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      busy_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write bypass and a pending-destination scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned NRD     = NRD_DEF,
  parameter int unsigned ZERO_R0 = 1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_ok;
  logic [DATA_W-1:0] rdata [NRD];
  logic              rrdy  [NRD];

  assign wr_ok = bus.wr_en && addr_writable(32'(bus.wr_addr), ZERO_R0 != 0);

  reg_file_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .flush    (bus.flush),
    .pending  (pending),
    .busy_cnt (bus.busy_cnt)
  );

  // Register 0 is never written when hardwired, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Bypass is suppressed while in reset since that write will be discarded.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp;
    assign ra       = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign byp      = wr_ok && rst_n && (bus.wr_addr == ra);
    assign rdata[k] = byp ? bus.wr_data : mem[ra];
    assign rrdy[k]  = byp || !pending[ra];
  end

  always_comb begin
    bus.rd_data  = '0;
    bus.rd_ready = '0;
    for (int k = 0; k < NRD; k++) begin
      bus.rd_data[k*DATA_W +: DATA_W] = rdata[k];
      bus.rd_ready[k]                 = rrdy[k];
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed vectors, queued expectations, decoupled monitor.
module tb_reg_file_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  typedef struct {
    string       name;
    logic [63:0] data;
    logic [1:0]  rdy;
    logic [5:0]  busy;
  } exp_t;

  logic clk;
  logic rst_n;
  logic smp;
  int   checks;
  int   errors;
  exp_t expq [$];

  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_R0(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops each queued expectation when the stimulus strobes a sample point.
  always @(posedge smp) begin
    while (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      checks++;
      if (bus.rd_data !== e.data) begin
        errors++;
        $display("FAIL %s rd_data got %h exp %h", e.name, bus.rd_data, e.data);
      end
      checks++;
      if (bus.rd_ready !== e.rdy) begin
        errors++;
        $display("FAIL %s rd_ready got %b exp %b", e.name, bus.rd_ready, e.rdy);
      end
      checks++;
      if (bus.busy_cnt !== e.busy) begin
        errors++;
        $display("FAIL %s busy_cnt got %0d exp %0d", e.name, bus.busy_cnt, e.busy);
      end
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] rsa, input logic fl,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rsv_en   = re;
    bus.rsv_addr = rsa;
    bus.flush    = fl;
    bus.rd_addr  = {ra1, ra0};
    #1;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, ra0, ra1);
  endtask

  task automatic expect_out(input string name, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] rdy, input logic [5:0] busy);
    exp_t e;
    e.name = name;
    e.data = {d1, d0};
    e.rdy  = rdy;
    e.busy = busy;
    expq.push_back(e);
    smp = 1'b1;
    #1;
    smp = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    smp    = 1'b0;
    rst_n  = 1'b0;
    idle(5'd5, 5'd5);
    expect_out("reset_state", 32'h0, 32'h0, 2'b11, 6'd0);
    rst_n = 1'b1;
    tick();

    idle(5'd5, 5'd5);
    expect_out("read5_after_reset", 32'h0, 32'h0, 2'b11, 6'd0);

    // Write with same-cycle bypass, then plain read next cycle.
    drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd3, 5'd5);
    expect_out("wr3_bypass", 32'hDEADBEEF, 32'h0, 2'b11, 6'd0);
    tick();
    idle(5'd3, 5'd5);
    expect_out("wr3_stored", 32'hDEADBEEF, 32'h0, 2'b11, 6'd0);

    // Reserve 7, observe pending, then write releases it with bypass.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd3);
    expect_out("rsv7_pre_edge", 32'h0, 32'hDEADBEEF, 2'b11, 6'd0);
    tick();
    idle(5'd7, 5'd3);
    expect_out("rsv7_pending", 32'h0, 32'hDEADBEEF, 2'b10, 6'd1);
    drive(1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 1'b0, 5'd7, 5'd3);
    expect_out("wr7_bypass_ready", 32'h12, 32'hDEADBEEF, 2'b11, 6'd1);
    tick();
    idle(5'd7, 5'd3);
    expect_out("wr7_cleared", 32'h12, 32'hDEADBEEF, 2'b11, 6'd0);

    // Same-cycle reserve and write to 9: data lands, reservation wins.
    drive(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
    expect_out("rsvwr9_bypass", 32'h55, 32'h55, 2'b11, 6'd0);
    tick();
    idle(5'd9, 5'd9);
    expect_out("rsvwr9_after", 32'h55, 32'h55, 2'b00, 6'd1);

    // Reserve 4,5,6 then flush with a concurrent reserve and write.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd6);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd4, 5'd6);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd4, 5'd6);
    tick();
    idle(5'd4, 5'd6);
    expect_out("rsv456_busy4", 32'h0, 32'h0, 2'b00, 6'd4);
    drive(1'b1, 5'd3, 32'h77, 1'b1, 5'd8, 1'b1, 5'd8, 5'd3);
    expect_out("flush_pre_edge", 32'h0, 32'h77, 2'b11, 6'd4);
    tick();
    idle(5'd8, 5'd3);
    expect_out("flush_after", 32'h0, 32'h77, 2'b11, 6'd0);

    // Register 0 ignores writes, reservations and never bypasses.
    drive(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    expect_out("r0_no_bypass", 32'h0, 32'h0, 2'b11, 6'd0);
    tick();
    idle(5'd0, 5'd0);
    expect_out("r0_after", 32'h0, 32'h0, 2'b11, 6'd0);

    // Reserve and write to different addresses: net count unchanged.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0, 5'd10, 5'd11);
    tick();
    drive(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 1'b0, 5'd10, 5'd11);
    expect_out("rsv11_wr10_pre", 32'h10, 32'h0, 2'b11, 6'd1);
    tick();
    idle(5'd10, 5'd11);
    expect_out("rsv11_wr10_after", 32'h10, 32'h0, 2'b01, 6'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 1'b0, 5'd10, 5'd11);
    tick();
    idle(5'd10, 5'd11);
    expect_out("rsv11_again", 32'h10, 32'h0, 2'b01, 6'd1);

    // Reset asserted between edges while a write is pending.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 5'd2, 5'd11);
    tick();
    drive(1'b1, 5'd2, 32'hA, 1'b0, 5'd0, 1'b0, 5'd2, 5'd11);
    expect_out("wr2_pre_reset", 32'hA, 32'h0, 2'b01, 6'd2);
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 32'h0, 32'h0, 2'b11, 6'd0);
    tick();
    expect_out("reset_held_edge", 32'h0, 32'h0, 2'b11, 6'd0);
    idle(5'd2, 5'd11);
    rst_n = 1'b1;
    tick();
    idle(5'd2, 5'd3);
    expect_out("after_reset_no_write", 32'h0, 32'h0, 2'b11, 6'd0);

    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left %0d exp 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
